// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN memory peripheral loader.
// Holds region codes and sizes, output-buffer depth and the loader's state and op encodings.
package cnn_pkg;

  // Write region codes placed on m_address during a WRITE stream
  localparam logic [2:0] REG_IMG = 3'd0;
  localparam logic [2:0] REG_L1  = 3'd1;
  localparam logic [2:0] REG_L2  = 3'd2;
  localparam logic [2:0] REG_L3  = 3'd3;
  localparam logic [2:0] REG_L4  = 3'd4;

  // Region byte sizes
  localparam int unsigned SIZE_IMG = 10000;
  localparam int unsigned SIZE_L1  = 400;
  localparam int unsigned SIZE_L2  = 12800;
  localparam int unsigned SIZE_L3  = 230400;
  localparam int unsigned SIZE_L4  = 10600;

  localparam int unsigned OUT_BUF_DEPTH = 16384;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRdReq,
    StRdWait,
    StRdOut
  } state_t;

  typedef enum logic {
    OpWrite = 1'b0,
    OpRead  = 1'b1
  } op_t;

  // Byte size of a write region; 0 for codes that name no region
  function automatic int unsigned region_bytes(input logic [2:0] region);
    case (region)
      REG_IMG: region_bytes = SIZE_IMG;
      REG_L1:  region_bytes = SIZE_L1;
      REG_L2:  region_bytes = SIZE_L2;
      REG_L3:  region_bytes = SIZE_L3;
      REG_L4:  region_bytes = SIZE_L4;
      default: region_bytes = 0;
    endcase
  endfunction

endpackage

// File: rtl/cnn_loader.sv
// Host-side bus master for the CNN memory peripheral.
// WRITE: streams cmd_len bytes from src_* into the region named by cmd_region (region code on
//   m_address; the peripheral auto-increments internally).
// READ:  fetches cmd_len bytes from the output buffer (m_address = byte index) onto out_*.
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   cmd_*               command channel (valid/ready, op, region, len)
//   src_*               write byte stream in (valid/ready)
//   out_*               readback byte stream out (valid/ready)
//   m_*                 peripheral bus; m_readdata valid one cycle after m_read
//   done, err           one-cycle completion / bad-region pulses
module cnn_loader
  import cnn_pkg::*;
#(
  parameter int unsigned ADDR_W   = 19,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned LEN_W    = 18,
  parameter int unsigned NUM_REGS = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [2:0]        cmd_region,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] src_data,
  input  logic              src_valid,
  output logic              src_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] m_address,
  output logic [DATA_W-1:0] m_writedata,
  output logic              m_chipselect,
  output logic              m_write,
  output logic              m_read,
  input  logic [DATA_W-1:0] m_readdata,
  output logic              done,
  output logic              err
);

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0]    cnt_inc;
  logic [2:0]          region_q, region_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                rd_done;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  // Registered bus-output stage
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic                m_cs_q, m_cs_d;
  logic                m_write_q, m_write_d;
  logic                m_read_q, m_read_d;

  assign cnt_inc = cnt_q + LEN_W'(1);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    region_d    = region_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    rd_done     = 1'b0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    m_cs_d      = 1'b0;
    m_write_d   = 1'b0;
    m_read_d    = 1'b0;
    cmd_ready   = (state_q == StIdle);
    src_ready   = (state_q == StWr);

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          len_d    = cmd_len;
          region_d = cmd_region;
          cnt_d    = '0;
          if (op_t'(cmd_op) == OpWrite && 32'(cmd_region) >= NUM_REGS) begin
            err_d = 1'b1;
          end else if (cmd_len == '0) begin
            done_d = 1'b1;
          end else if (op_t'(cmd_op) == OpWrite) begin
            state_d = StWr;
          end else begin
            // First read strobe issues on entry to StRdReq
            state_d  = StRdReq;
            m_cs_d   = 1'b1;
            m_read_d = 1'b1;
            m_addr_d = '0;
          end
        end
      end
      StWr: begin
        if (src_valid) begin
          m_cs_d    = 1'b1;
          m_write_d = 1'b1;
          m_addr_d  = ADDR_W'(region_q);
          m_wdata_d = src_data;
          cnt_d     = cnt_inc;
          // Final byte: done rides with its registered write
          if (cnt_inc == len_q) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      StRdReq: begin
        state_d = StRdWait;
      end
      StRdWait: begin
        out_data_d  = m_readdata;
        out_valid_d = 1'b1;
        state_d     = StRdOut;
      end
      StRdOut: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          cnt_d       = cnt_inc;
          if (cnt_inc == len_q) begin
            rd_done = 1'b1;
            state_d = StIdle;
          end else begin
            state_d  = StRdReq;
            m_cs_d   = 1'b1;
            m_read_d = 1'b1;
            m_addr_d = ADDR_W'(cnt_inc);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      len_q       <= '0;
      cnt_q       <= '0;
      region_q    <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      m_cs_q      <= 1'b0;
      m_write_q   <= 1'b0;
      m_read_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      region_q    <= region_d;
      done_q      <= done_d;
      err_q       <= err_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      m_cs_q      <= m_cs_d;
      m_write_q   <= m_write_d;
      m_read_q    <= m_read_d;
    end
  end

  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign m_address    = m_addr_q;
  assign m_writedata  = m_wdata_q;
  assign m_chipselect = m_cs_q;
  assign m_write      = m_write_q;
  assign m_read       = m_read_q;
  // Read completion is reported in the cycle of the last output handshake
  assign done         = done_q | rd_done;
  assign err          = err_q;

endmodule

// File: tb/tb_cnn_loader.sv
// Scoreboard bench for cnn_loader: stimulus pushes expected bus writes, read addresses and
// output bytes into queues; a negedge monitor pops and compares. Event cycles are logged and
// compared against hand-computed offsets from the command issue cycle.
module tb_cnn_loader;
  import cnn_pkg::*;

  localparam int unsigned ADDR_W = 19;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned LEN_W  = 18;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_op = 1'b0;
  logic [2:0]        cmd_region = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic [DATA_W-1:0] src_data = '0;
  logic              src_valid = 1'b0;
  logic              src_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [ADDR_W-1:0] m_address;
  logic [DATA_W-1:0] m_writedata;
  logic              m_chipselect;
  logic              m_write;
  logic              m_read;
  logic [DATA_W-1:0] m_readdata = '0;
  logic              done;
  logic              err;

  cnn_loader dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_region   (cmd_region),
    .cmd_len      (cmd_len),
    .src_data     (src_data),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .m_address    (m_address),
    .m_writedata  (m_writedata),
    .m_chipselect (m_chipselect),
    .m_write      (m_write),
    .m_read       (m_read),
    .m_readdata   (m_readdata),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Peripheral model: read data 0xA0 + address, one cycle after m_read
  always @(posedge clk) if (m_read) m_readdata <= 8'hA0 + m_address[7:0];

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t               exp_wr[$];
  logic [ADDR_W-1:0] exp_rd[$];
  logic [DATA_W-1:0] exp_out[$];
  int wr_cyc[$], rd_cyc[$], out_cyc[$], done_cyc[$], err_cyc[$];
  int cs_cnt = 0;
  logic              stall_q = 1'b0;
  logic [DATA_W-1:0] stall_data = '0;

  always @(negedge clk) begin
    check("strobe_exclusive", longint'(m_write & m_read), 0);
    check("cs_with_strobe", longint'(m_chipselect), longint'(m_write | m_read));
    if (m_chipselect) cs_cnt++;
    if (m_write) begin
      wr_cyc.push_back(cyc);
      if (exp_wr.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL wr_unexpected: got write addr %0d data 0x%0h, expected none",
                 m_address, m_writedata);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        check("wr_addr", longint'(m_address), longint'(e.addr));
        check("wr_data", longint'(m_writedata), longint'(e.data));
      end
    end
    if (m_read) begin
      rd_cyc.push_back(cyc);
      if (exp_rd.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rd_unexpected: got read addr %0d, expected none", m_address);
      end else begin
        check("rd_addr", longint'(m_address), longint'(exp_rd.pop_front()));
      end
    end
    if (stall_q) begin
      check("out_valid_held", longint'(out_valid), 1);
      check("out_data_held", longint'(out_data), longint'(stall_data));
    end
    stall_q    = out_valid & ~out_ready;
    stall_data = out_data;
    if (out_valid && out_ready) begin
      out_cyc.push_back(cyc);
      if (exp_out.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL out_unexpected: got byte 0x%0h, expected none", out_data);
      end else begin
        check("out_data", longint'(out_data), longint'(exp_out.pop_front()));
      end
    end
    if (done) done_cyc.push_back(cyc);
    if (err) err_cyc.push_back(cyc);
  end

  task automatic clear_logs();
    wr_cyc.delete(); rd_cyc.delete(); out_cyc.delete();
    done_cyc.delete(); err_cyc.delete();
    cs_cnt = 0;
  endtask

  task automatic cmp_cyc(input string name, input int base, input int got[$], input int exp[$]);
    check({name, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) check(name, got[i] - base, exp[i]);
  endtask

  task automatic check_queues_empty(input string name);
    check({name, "_wr_left"}, exp_wr.size(), 0);
    check({name, "_rd_left"}, exp_rd.size(), 0);
    check({name, "_out_left"}, exp_out.size(), 0);
  endtask

  // Issues a one-cycle command; returns with time just after the accepting edge
  task automatic send_cmd(input logic op, input logic [2:0] region, input logic [LEN_W-1:0] len,
                          output int base);
    @(posedge clk); #1;
    base       = cyc;
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_region = region;
    cmd_len    = len;
    @(negedge clk);
    check("cmd_ready_at_issue", longint'(cmd_ready), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Drives bytes under a per-cycle src_valid pattern until n handshakes have happened
  task automatic drive_src(input logic [15:0] pat, input logic [7:0] bytes[$], input int n);
    int  k = 0;
    logic hs;
    for (int j = 0; j < 16 && k < n; j++) begin
      src_valid = pat[j];
      src_data  = bytes[k];
      @(negedge clk);
      hs = src_valid & src_ready;
      @(posedge clk); #1;
      if (hs) k++;
    end
    src_valid = 1'b0;
    if (k < n) begin
      n_checks++; n_fail++;
      $display("FAIL src_timeout: got %0d handshakes, expected %0d", k, n);
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL %s_idle_timeout: got cmd_ready 0, expected 1 within 40 cycles", name);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int e[$];
    logic [7:0] b[$];

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", longint'(cmd_ready), 1);
    check("rst_src_ready", longint'(src_ready), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_m_cs", longint'(m_chipselect), 0);
    check("rst_m_write", longint'(m_write), 0);
    check("rst_m_read", longint'(m_read), 0);
    check("rst_m_address", longint'(m_address), 0);
    check("rst_done", longint'(done), 0);
    check("rst_err", longint'(err), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // 1: WRITE region 1, len 4, full rate
    clear_logs();
    b = {8'd11, 8'd22, 8'd33, 8'd44};
    foreach (b[i]) exp_wr.push_back('{addr: ADDR_W'(REG_L1), data: b[i]});
    send_cmd(OpWrite, REG_L1, 18'd4, base);
    drive_src(16'hFFFF, b, 4);
    check("t1_cmd_ready_after", longint'(cmd_ready), 1);
    check("t1_src_ready_after", longint'(src_ready), 0);
    wait_idle("t1");
    e = {2, 3, 4, 5}; cmp_cyc("t1_wr_cyc", base, wr_cyc, e);
    e = {5};          cmp_cyc("t1_done_cyc", base, done_cyc, e);
    check_queues_empty("t1");

    // 2: WRITE region 0, len 3, src_valid 1,0,1,0,1
    clear_logs();
    b = {8'h5A, 8'h5B, 8'h5C};
    foreach (b[i]) exp_wr.push_back('{addr: ADDR_W'(REG_IMG), data: b[i]});
    send_cmd(OpWrite, REG_IMG, 18'd3, base);
    drive_src(16'b0000_0000_0001_0101, b, 3);
    wait_idle("t2");
    e = {2, 4, 6}; cmp_cyc("t2_wr_cyc", base, wr_cyc, e);
    e = {6};       cmp_cyc("t2_done_cyc", base, done_cyc, e);
    check_queues_empty("t2");

    // 3: READ len 3, out_ready low two cycles while byte 1 is presented
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      exp_rd.push_back(ADDR_W'(i));
      exp_out.push_back(8'hA0 + 8'(i));
    end
    send_cmd(OpRead, 3'd7, 18'd3, base);
    for (int j = 1; j <= 14; j++) begin
      out_ready = !(j == 6 || j == 7);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_idle("t3");
    e = {1, 4, 9};  cmp_cyc("t3_rd_cyc", base, rd_cyc, e);
    e = {3, 8, 11}; cmp_cyc("t3_out_cyc", base, out_cyc, e);
    e = {11};       cmp_cyc("t3_done_cyc", base, done_cyc, e);
    check("t3_no_write", wr_cyc.size(), 0);
    check_queues_empty("t3");

    // 4a: WRITE to region 5 -> err only
    clear_logs();
    send_cmd(OpWrite, 3'd5, 18'd4, base);
    wait_idle("t4a");
    e = {1}; cmp_cyc("t4a_err_cyc", base, err_cyc, e);
    check("t4a_no_done", done_cyc.size(), 0);
    check("t4a_no_cs", cs_cnt, 0);

    // 4b: WRITE len 0 -> done only
    clear_logs();
    send_cmd(OpWrite, REG_L2, 18'd0, base);
    wait_idle("t4b");
    e = {1}; cmp_cyc("t4b_done_cyc", base, done_cyc, e);
    check("t4b_no_err", err_cyc.size(), 0);
    check("t4b_no_cs", cs_cnt, 0);

    // 5: reset after 2 of 6 bytes, then a fresh WRITE
    clear_logs();
    b = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    exp_wr.push_back('{addr: ADDR_W'(REG_L3), data: 8'd1});
    exp_wr.push_back('{addr: ADDR_W'(REG_L3), data: 8'd2});
    send_cmd(OpWrite, REG_L3, 18'd6, base);
    drive_src(16'hFFFF, b, 2);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("t5_rst_m_write", longint'(m_write), 0);
    check("t5_rst_m_read", longint'(m_read), 0);
    check("t5_rst_m_cs", longint'(m_chipselect), 0);
    check("t5_rst_cmd_ready", longint'(cmd_ready), 1);
    check("t5_rst_src_ready", longint'(src_ready), 0);
    check("t5_rst_done", longint'(done), 0);
    repeat (3) @(posedge clk);
    #1;
    e = {2, 3}; cmp_cyc("t5_wr_cyc", base, wr_cyc, e);
    check("t5_no_done", done_cyc.size(), 0);
    check_queues_empty("t5a");
    clear_logs();
    b = {8'h77, 8'h88};
    foreach (b[i]) exp_wr.push_back('{addr: ADDR_W'(REG_L4), data: b[i]});
    send_cmd(OpWrite, REG_L4, 18'd2, base);
    drive_src(16'hFFFF, b, 2);
    wait_idle("t5b");
    e = {2, 3}; cmp_cyc("t5b_wr_cyc", base, wr_cyc, e);
    e = {3};    cmp_cyc("t5b_done_cyc", base, done_cyc, e);
    check_queues_empty("t5b");

    // 6: command presented mid-READ is ignored
    clear_logs();
    for (int i = 0; i < 2; i++) begin
      exp_rd.push_back(ADDR_W'(i));
      exp_out.push_back(8'hA0 + 8'(i));
    end
    send_cmd(OpRead, 3'd0, 18'd2, base);
    @(posedge clk); #1;
    cmd_valid  = 1'b1;
    cmd_op     = OpWrite;
    cmd_region = REG_IMG;
    cmd_len    = 18'd7;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("t6_cmd_ready_busy", longint'(cmd_ready), 0);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    wait_idle("t6");
    e = {1, 4}; cmp_cyc("t6_rd_cyc", base, rd_cyc, e);
    e = {3, 6}; cmp_cyc("t6_out_cyc", base, out_cyc, e);
    e = {6};    cmp_cyc("t6_done_cyc", base, done_cyc, e);
    check("t6_no_write", wr_cyc.size(), 0);
    check_queues_empty("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
